// File: rtl/lamp_sequencer.sv
// rtl/lamp_sequencer.sv - stairwell lamp sequencer driven by N multi-way toggle switches
//
// Purpose:
//   Synchronizes and debounces the parity of N toggle switches. Any accepted
//   parity change is a single event that drives a four-state lamp sequence:
//   steady on, blink warning, auto-off. A second event shortly after switch-on
//   latches the lamp on (HOLD) until the next event.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   sw     - raw asynchronous switch levels [N_SW-1:0]
//   lamp   - registered lamp drive
//   warn   - high while in the blink-warning phase
//   state  - current sequence state: OFF=00, ON=01, WARN=10, HOLD=11

module lamp_sequencer #(
    parameter int unsigned N_SW       = 3,
    parameter int unsigned CNT_W      = 28,
    parameter int unsigned DEB        = 1_000_000,
    parameter int unsigned T_ON       = 200_000_000,
    parameter int unsigned T_WARN     = 50_000_000,
    parameter int unsigned BLINK_HALF = 5_000_000,
    parameter int unsigned T_DBL      = 30_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw,
    output logic            lamp,
    output logic            warn,
    output logic [1:0]      state
);

    localparam logic [1:0] S_OFF  = 2'b00;
    localparam logic [1:0] S_ON   = 2'b01;
    localparam logic [1:0] S_WARN = 2'b10;
    localparam logic [1:0] S_HOLD = 2'b11;

    localparam int unsigned DEB_W = $clog2(DEB + 1);

    localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEB);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TON_LD   = CNT_W'(T_ON - 1);
    localparam logic [CNT_W-1:0] TWARN_LD = CNT_W'(T_WARN - 1);
    localparam logic [CNT_W-1:0] BLINK_LD = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] DBL_LD   = CNT_W'(T_DBL - 1);

    // ------------------------------------------------------------------
    // Input path registers
    // ------------------------------------------------------------------
    logic [N_SW-1:0]  sync1_q, sync1_d;
    logic [N_SW-1:0]  sync2_q, sync2_d;
    logic             p_last_q, p_last_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             p_db_q, p_db_d;
    logic             loaded_q, loaded_d;
    logic             evt_q, evt_d;

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic             lamp_q, lamp_d;
    logic             warn_q, warn_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] dbl_q, dbl_d;
    logic             dbl_armed_q, dbl_armed_d;
    logic [CNT_W-1:0] blink_q, blink_d;

    logic             p;
    logic             deb_stable;
    logic [CNT_W-1:0] tmr_dec;
    logic [CNT_W-1:0] dbl_dec;
    logic [CNT_W-1:0] blink_dec;

    // ------------------------------------------------------------------
    // Synchronizer, parity and debounce
    // ------------------------------------------------------------------
    // deb_cnt_q counts how many consecutive cycles the current parity
    // (p_last_q) has been seen, saturating at DEB. Once saturated the held
    // value is accepted; evt is registered so it is a clean one-cycle pulse.
    always_comb begin
        sync1_d    = sw;
        sync2_d    = sync1_q;
        p          = ^sync2_q;
        p_last_d   = p;
        deb_cnt_d  = deb_cnt_q;
        p_db_d     = p_db_q;
        loaded_d   = loaded_q;
        evt_d      = 1'b0;
        deb_stable = (deb_cnt_q == DEB_FULL);

        if (deb_stable) begin
            p_db_d   = p_last_q;
            loaded_d = 1'b1;
            // The very first accepted parity after reset is adopted silently
            // so the lamp never lights just because of switch positions.
            evt_d    = loaded_q && (p_last_q != p_db_q);
        end

        if (p != p_last_q) begin
            deb_cnt_d = DEB_ONE;
        end else if (!deb_stable) begin
            deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Lamp sequence
    // ------------------------------------------------------------------
    always_comb begin
        tmr_dec   = (tmr_q   == CNT_ZERO) ? CNT_ZERO : tmr_q   - CNT_ONE;
        dbl_dec   = (dbl_q   == CNT_ZERO) ? CNT_ZERO : dbl_q   - CNT_ONE;
        blink_dec = (blink_q == CNT_ZERO) ? CNT_ZERO : blink_q - CNT_ONE;

        state_d     = state_q;
        lamp_d      = lamp_q;
        tmr_d       = tmr_q;
        dbl_d       = dbl_q;
        dbl_armed_d = dbl_armed_q;
        blink_d     = blink_q;

        case (state_q)
            S_OFF: begin
                lamp_d = 1'b0;
                if (evt_q) begin
                    state_d     = S_ON;
                    lamp_d      = 1'b1;
                    tmr_d       = TON_LD;
                    dbl_d       = DBL_LD;
                    dbl_armed_d = 1'b1;
                end
            end

            S_ON: begin
                lamp_d = 1'b1;
                // The double-flip window runs independently of the on-timer
                // so a retrigger after the window cannot reopen it.
                dbl_d  = dbl_dec;
                if (dbl_q == CNT_ZERO) begin
                    dbl_armed_d = 1'b0;
                end
                if (evt_q) begin
                    if (dbl_armed_q) begin
                        state_d     = S_HOLD;
                        dbl_armed_d = 1'b0;
                        dbl_d       = CNT_ZERO;
                    end else begin
                        tmr_d = TON_LD;
                    end
                end else if (tmr_q == CNT_ZERO) begin
                    state_d = S_WARN;
                    tmr_d   = TWARN_LD;
                    blink_d = BLINK_LD;
                end else begin
                    tmr_d = tmr_dec;
                end
            end

            S_WARN: begin
                if (evt_q) begin
                    // Rescue flip: back to steady on, never into HOLD.
                    state_d     = S_ON;
                    lamp_d      = 1'b1;
                    tmr_d       = TON_LD;
                    dbl_d       = CNT_ZERO;
                    dbl_armed_d = 1'b0;
                end else if (tmr_q == CNT_ZERO) begin
                    state_d = S_OFF;
                    lamp_d  = 1'b0;
                end else begin
                    tmr_d = tmr_dec;
                    if (blink_q == CNT_ZERO) begin
                        lamp_d  = ~lamp_q;
                        blink_d = BLINK_LD;
                    end else begin
                        blink_d = blink_dec;
                    end
                end
            end

            S_HOLD: begin
                lamp_d = 1'b1;
                if (evt_q) begin
                    state_d = S_OFF;
                    lamp_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_OFF;
                lamp_d  = 1'b0;
            end
        endcase

        warn_d = (state_d == S_WARN);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            p_last_q    <= 1'b0;
            deb_cnt_q   <= '0;
            p_db_q      <= 1'b0;
            loaded_q    <= 1'b0;
            evt_q       <= 1'b0;
            state_q     <= S_OFF;
            lamp_q      <= 1'b0;
            warn_q      <= 1'b0;
            tmr_q       <= '0;
            dbl_q       <= '0;
            dbl_armed_q <= 1'b0;
            blink_q     <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            p_last_q    <= p_last_d;
            deb_cnt_q   <= deb_cnt_d;
            p_db_q      <= p_db_d;
            loaded_q    <= loaded_d;
            evt_q       <= evt_d;
            state_q     <= state_d;
            lamp_q      <= lamp_d;
            warn_q      <= warn_d;
            tmr_q       <= tmr_d;
            dbl_q       <= dbl_d;
            dbl_armed_q <= dbl_armed_d;
            blink_q     <= blink_d;
        end
    end

    assign lamp  = lamp_q;
    assign warn  = warn_q;
    assign state = state_q;

endmodule

// File: tb/tb_lamp_sequencer.sv
// tb/tb_lamp_sequencer.sv - self-checking bench for lamp_sequencer against a timestamp-based model

module tb_lamp_sequencer;

    localparam int N_SW       = 3;
    localparam int CNT_W      = 28;
    localparam int DEB        = 4;
    localparam int T_ON       = 20;
    localparam int T_WARN     = 8;
    localparam int BLINK_HALF = 2;
    localparam int T_DBL      = 10;

    localparam int M_OFF  = 0;
    localparam int M_ON   = 1;
    localparam int M_WARN = 2;
    localparam int M_HOLD = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_SW-1:0] sw    = 3'b001;
    logic            lamp;
    logic            warn;
    logic [1:0]      state;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    lamp_sequencer #(
        .N_SW      (N_SW),
        .CNT_W     (CNT_W),
        .DEB       (DEB),
        .T_ON      (T_ON),
        .T_WARN    (T_WARN),
        .BLINK_HALF(BLINK_HALF),
        .T_DBL     (T_DBL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .lamp (lamp),
        .warn (warn),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: event detection from a parity history, sequence
    // timing from edge timestamps rather than down-counters.
    // ------------------------------------------------------------------
    int edge_n;
    int mode;
    int seg_start;
    int on_entry;
    bit dbl_ok;
    bit m_loaded, m_pdb, m_evt;
    bit samp_q[$];
    bit hist_q[$];
    bit m_lamp, m_warn;
    int m_state;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n    = 0;
            mode      = M_OFF;
            seg_start = 0;
            on_entry  = 0;
            dbl_ok    = 1'b0;
            m_loaded  = 1'b0;
            m_pdb     = 1'b0;
            m_evt     = 1'b0;
            samp_q    = {1'b0, 1'b0};
            hist_q    = {};
            m_lamp    = 1'b0;
            m_warn    = 1'b0;
            m_state   = M_OFF;
        end else begin
            bit ev, p_now, all_eq;
            edge_n++;
            ev = m_evt;
            case (mode)
                M_OFF: if (ev) begin
                    mode = M_ON; seg_start = edge_n; on_entry = edge_n; dbl_ok = 1'b1;
                end
                M_ON: if (ev) begin
                    if (dbl_ok && (edge_n - on_entry) <= T_DBL) mode = M_HOLD;
                    else seg_start = edge_n;
                end else if (edge_n - seg_start >= T_ON) begin
                    mode = M_WARN; seg_start = edge_n;
                end
                M_WARN: if (ev) begin
                    mode = M_ON; seg_start = edge_n; dbl_ok = 1'b0;
                end else if (edge_n - seg_start >= T_WARN) begin
                    mode = M_OFF;
                end
                default: if (ev) mode = M_OFF;
            endcase
            m_state = mode;
            m_warn  = (mode == M_WARN);
            if (mode == M_OFF) m_lamp = 1'b0;
            else if (mode == M_WARN) m_lamp = (((edge_n - seg_start) / BLINK_HALF) % 2) == 0;
            else m_lamp = 1'b1;

            // parity seen by the debouncer lags the pins by two edges
            p_now = samp_q.pop_front();
            samp_q.push_back(^sw);
            m_evt = 1'b0;
            if (hist_q.size() == DEB) begin
                all_eq = 1'b1;
                foreach (hist_q[i]) if (hist_q[i] != hist_q[0]) all_eq = 1'b0;
                if (all_eq) begin
                    if (!m_loaded) begin
                        m_loaded = 1'b1;
                        m_pdb    = hist_q[0];
                    end else if (hist_q[0] != m_pdb) begin
                        m_pdb = hist_q[0];
                        m_evt = 1'b1;
                    end
                end
            end
            hist_q.push_back(p_now);
            if (hist_q.size() > DEB) void'(hist_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_lamp",  32'(lamp),  32'(m_lamp));
            check("model_warn",  32'(warn),  32'(m_warn));
            check("model_state", 32'(state), 32'(m_state));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;

        rst_n = 1'b0;
        sw    = 3'b001;
        repeat (3) @(negedge clk);
        check("reset_lamp",  32'(lamp),  32'd0);
        check("reset_state", 32'(state), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // silent first load
        repeat (50) @(negedge clk);
        check("first_load_lamp",  32'(lamp),  32'd0);
        check("first_load_state", 32'(state), 32'd0);

        // single flip: latency, full ON/WARN/OFF run
        sw[0] = ~sw[0];
        n = 0;
        @(negedge clk);
        while (!lamp && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("on_latency", 32'(n), 32'd7);
        repeat (40) @(negedge clk);
        check("auto_off_state", 32'(state), 32'd0);
        check("auto_off_lamp",  32'(lamp),  32'd0);

        // short pulse and even-count flip are both ignored
        sw[1] = ~sw[1];
        repeat (3) @(negedge clk);
        sw[1] = ~sw[1];
        repeat (20) @(negedge clk);
        check("short_pulse_lamp", 32'(lamp), 32'd0);
        sw = sw ^ 3'b110;
        repeat (20) @(negedge clk);
        check("even_flip_lamp", 32'(lamp), 32'd0);

        // double flip: second event lands 6 cycles after the lamp lights
        sw[0] = ~sw[0];
        repeat (6) @(negedge clk);
        sw[2] = ~sw[2];
        repeat (200) @(negedge clk);
        check("hold_state", 32'(state), 32'd3);
        check("hold_lamp",  32'(lamp),  32'd1);
        sw[0] = ~sw[0];
        repeat (15) @(negedge clk);
        check("hold_exit_state", 32'(state), 32'd0);
        check("hold_exit_lamp",  32'(lamp),  32'd0);

        // rescue flip during WARN; its event coincides with WARN expiry
        sw[1] = ~sw[1];
        n = 0;
        while (!warn && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("warn_reached", 32'(warn), 32'd1);
        sw[2] = ~sw[2];
        repeat (10) @(negedge clk);
        check("rescue_state", 32'(state), 32'd1);
        repeat (40) @(negedge clk);
        check("rescue_off_state", 32'(state), 32'd0);

        // event aligned with on-timer expiry
        sw[0] = ~sw[0];
        n = 0;
        while (!lamp && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("align_lamp_up", 32'(lamp), 32'd1);
        repeat (12) @(negedge clk);
        sw[1] = ~sw[1];
        repeat (8) @(negedge clk);
        check("align_state", 32'(state), 32'd1);
        repeat (19) @(negedge clk);
        check("align_reload_state", 32'(state), 32'd1);
        @(negedge clk);
        check("align_reload_warn", 32'(state), 32'd2);
        repeat (20) @(negedge clk);

        // asynchronous reset during WARN
        sw[2] = ~sw[2];
        n = 0;
        while (!warn && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("warn_before_reset", 32'(warn), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_warn_lamp",  32'(lamp),  32'd0);
        check("rst_warn_warn",  32'(warn),  32'd0);
        check("rst_warn_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_lamp", 32'(lamp), 32'd0);

        // asynchronous reset during HOLD
        sw[0] = ~sw[0];
        repeat (6) @(negedge clk);
        sw[1] = ~sw[1];
        repeat (30) @(negedge clk);
        check("hold_before_reset", 32'(state), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        check("rst_hold_lamp",  32'(lamp),  32'd0);
        check("rst_hold_warn",  32'(warn),  32'd0);
        check("rst_hold_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        // randomized flips, short and long gaps, compared cycle by cycle
        for (int i = 0; i < 150; i++) begin
            sw = sw ^ N_SW'($urandom_range(0, 7));
            repeat ($urandom_range(1, 25)) @(negedge clk);
        end
        repeat (60) @(negedge clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
